// File: rtl/fix2sfp_pkg.sv
// Shared field widths and constants for the fixed-point to small-float (SFP) converter.
package fix2sfp_pkg;
  localparam int C_FIX_W     = 21;
  localparam int C_EXP_W     = 4;
  localparam int C_SIG_W     = 4;
  localparam int C_SFP_W     = 1 + C_EXP_W + C_SIG_W;
  localparam int C_EXP_BIAS  = 3;
  localparam int C_SMALL_EXP = 2;
endpackage

// File: rtl/fix2sfp.sv
// Combinational fix-to-SFP converter: sign/one's-complement magnitude, leading-one
// normalisation, round half-up on the guard bit, exponent saturation at full scale.
module fix2sfp
  import fix2sfp_pkg::*;
#(
  parameter int FIX_W = C_FIX_W,
  parameter int EXP_W = C_EXP_W,
  parameter int SIG_W = C_SIG_W,
  parameter int SFP_W = C_SFP_W
)(
  input  logic signed [FIX_W-1:0] i_fix,
  output logic        [SFP_W-1:0] o_sfp
);
  localparam int WIN_W = SIG_W + 1;
  typedef logic [WIN_W-1:0] win_t;

  logic             w_sign;
  logic [FIX_W-1:0] w_mag;
  win_t             w_win;
  logic [EXP_W-1:0] w_exp;
  logic [SIG_W-1:0] w_sig;
  int               w_pos;

  function automatic int lead_pos(input logic [FIX_W-1:0] m);
    int p;
    p = -1;
    for (int b = 0; b < FIX_W; b++) begin
      if (m[b]) p = b;
    end
    return p;
  endfunction

  function automatic logic [EXP_W+SIG_W-1:0] sat_exp(input int e, input logic [SIG_W-1:0] s);
    if (e > (1 << EXP_W) - 1) return '1;
    return {EXP_W'(e), s};
  endfunction

  // Window is {mantissa, guard}; a carry out of the mantissa bumps the exponent.
  function automatic logic [EXP_W+SIG_W-1:0] round_half_up(input int e, input win_t w);
    logic [SIG_W:0] m;
    int             e_r;
    m   = {1'b0, w[WIN_W-1:1]} + {{SIG_W{1'b0}}, w[0]};
    e_r = e;
    if (m[SIG_W]) begin
      e_r = e + 1;
      m   = '0;
    end
    return sat_exp(e_r, m[SIG_W-1:0]);
  endfunction

  always_comb begin
    w_sign = i_fix[FIX_W-1];
    w_mag  = w_sign ? ~i_fix : i_fix;
    w_pos  = lead_pos(w_mag);
    w_win  = '0;
    w_exp  = '0;
    w_sig  = '0;
    if (w_pos == SIG_W) begin
      w_exp = EXP_W'(C_SMALL_EXP);
      w_sig = w_mag[SIG_W-1:0];
    end else if (w_pos > SIG_W) begin
      w_win          = win_t'(w_mag >> (w_pos - WIN_W));
      {w_exp, w_sig} = round_half_up(w_pos - C_EXP_BIAS, w_win);
    end
  end

  assign o_sfp = {w_sign, w_exp, w_sig};
endmodule

// File: rtl/fix2sfp_sched.sv
// Round-robin scheduler sharing one fix2sfp converter among NREQ requesters,
// with a two-stage valid/ready pipeline (S1 holds the operand, S2 the result).
module fix2sfp_sched
  import fix2sfp_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int FIX_W = C_FIX_W,
  parameter int EXP_W = C_EXP_W,
  parameter int SIG_W = C_SIG_W,
  parameter int SFP_W = C_SFP_W
)(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*FIX_W-1:0]     req_fix,
  output logic [NREQ-1:0]           req_ready,
  output logic                      out_valid,
  output logic [SFP_W-1:0]          out_sfp,
  output logic [$clog2(NREQ)-1:0]   out_id,
  input  logic                      out_ready,
  output logic                      busy
);
  localparam int ID_W = $clog2(NREQ);

  logic [ID_W-1:0]         r_ptr;
  logic                    r_vld_p1;
  logic                    r_vld_p2;
  logic signed [FIX_W-1:0] r_fix_p1;
  logic [ID_W-1:0]         r_id_p1;

  logic                    w_found;
  logic [ID_W-1:0]         w_gnt_idx;
  int                      w_scan;
  logic                    w_s2_load;
  logic                    w_s1_open;
  logic                    w_accept;
  logic [SFP_W-1:0]        w_sfp_p1;

  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_scan    = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_scan = (int'(r_ptr) + k) % NREQ;
      if (!w_found && req_valid[w_scan]) begin
        w_found   = 1'b1;
        w_gnt_idx = ID_W'(w_scan);
      end
    end
  end

  assign w_s2_load = !r_vld_p2 || out_ready;
  assign w_s1_open = !r_vld_p1 || w_s2_load;
  assign w_accept  = rst_n && w_found && w_s1_open;

  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      if (w_accept) r_ptr <= (w_gnt_idx == ID_W'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
      if (w_accept)       r_vld_p1 <= 1'b1;
      else if (w_s2_load) r_vld_p1 <= 1'b0;
      if (w_s2_load) r_vld_p2 <= r_vld_p1;
    end
  end

  // ---- S1: accepted operand and its requester id ----
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_fix_p1 <= req_fix[int'(w_gnt_idx)*FIX_W +: FIX_W];
      r_id_p1  <= w_gnt_idx;
    end
  end

  fix2sfp #(
    .FIX_W (FIX_W),
    .EXP_W (EXP_W),
    .SIG_W (SIG_W),
    .SFP_W (SFP_W)
  ) u_conv (
    .i_fix (r_fix_p1),
    .o_sfp (w_sfp_p1)
  );

  // ---- S2: converted result, drives the output port directly ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sfp <= '0;
      out_id  <= '0;
    end else if (w_s2_load && r_vld_p1) begin
      out_sfp <= w_sfp_p1;
      out_id  <= r_id_p1;
    end
  end

  assign out_valid = r_vld_p2;
  assign busy      = r_vld_p1 | r_vld_p2;
endmodule

// File: doc/fix2sfp_sched.md
FIX2SFP_SCHED -- requirements
Module: fix2sfp_sched

Interface
- REQ-001: Parameter NREQ, default 4, number of requesters sharing one converter.
- REQ-002: Parameter FIX_W, default 21, two's-complement fixed-point input width.
- REQ-003: Parameter EXP_W, default 4, SFP exponent width.
- REQ-004: Parameter SIG_W, default 4, SFP mantissa width.
- REQ-005: Parameter SFP_W, default 9, SFP output width (1+EXP_W+SIG_W).
- REQ-006: Port clk, input, 1, the single clock; all state on rising edge.
- REQ-007: Port rst_n, input, 1, reset, asynchronous assert, active-low.
- REQ-008: Port req_valid, input, NREQ, per-requester value present.
- REQ-009: Port req_fix, input, NREQ*FIX_W, packed fixed-point values; requester i at [i*FIX_W +: FIX_W].
- REQ-010: Port req_ready, output, NREQ, one-hot or zero grant; transfer when req_valid[i] and req_ready[i] are both high.
- REQ-011: Port out_valid, output, 1, converted result present.
- REQ-012: Port out_sfp, output, SFP_W, {sign, exponent, mantissa}.
- REQ-013: Port out_id, output, clog2(NREQ), index of originating requester.
- REQ-014: Port out_ready, input, 1, downstream accepts when out_valid and out_ready are both high.
- REQ-015: Port busy, output, 1, high while either pipeline stage holds data.

Function
- REQ-016: The block SHALL arbitrate round-robin: the search starts at ptr and wraps modulo NREQ; the first requester with req_valid high is granted.
- REQ-017: ptr SHALL become (granted index + 1) mod NREQ only on an accepted transfer, and SHALL hold otherwise.
- REQ-018: req_ready SHALL be combinational, asserted only for the granted index, and only when stage S1 can load (S1 empty, or S1 advancing this cycle).
- REQ-019: S1 SHALL register the accepted fix value and its id; the conversion SHALL be combinational on the S1 contents.
- REQ-020: S2 SHALL register the conversion result and id, driving out_sfp, out_id and out_valid directly from flops.
- REQ-021: S2 SHALL load when S2 is empty or out_ready is high; S1 SHALL advance into S2 under the same condition.
- REQ-022: Latency SHALL be 2 cycles from the accept edge to the out_valid edge, and throughput SHALL be 1 per cycle with out_ready held high.
- REQ-023: While out_valid is high and out_ready is low, out_sfp and out_id SHALL hold stable, S1 SHALL hold, and req_ready SHALL be all-zero once S1 is full.
- REQ-024: When S2 drains and S1 refills in the same cycle, the block SHALL lose no data and issue no duplicate.
- REQ-025: Conversion, sign: the block SHALL take the sign from the fix MSB, one's-complement negatives, locate the leading one at pos, and set exponent = pos-3.
- REQ-026: Conversion, mantissa: the block SHALL take the 4 bits below the leading one, round half-up on the next bit, and on mantissa overflow zero the mantissa and increment the exponent.
- REQ-027: Conversion, small values: for pos=4 the exponent SHALL be 2 with no rounding; for pos<4, including zero, exponent and mantissa SHALL be 0 with the sign retained.
- REQ-028: If req_valid drops without a transfer, nothing SHALL be recorded; requesters SHALL hold req_fix stable while valid.

Reset
- REQ-029: On rst_n low, asynchronously: S1 and S2 valid bits = 0, out_valid = 0, out_sfp = 0, out_id = 0, ptr = 0, busy = 0, req_ready = 0.
- REQ-030: Reset mid-operation SHALL discard in-flight data; the first grant after release SHALL search from index 0.
- REQ-031: Data-path flops SHALL need no reset beyond the outputs listed above.

Structure
- REQ-032: A shared package SHALL hold the SFP field widths (EXP_W, SIG_W, SFP_W), FIX_W, and the exponent bias offset 3.
- REQ-033: The conversion SHALL be a single sub-module, fix2sfp (the team's fix-to-SFP converter), instantiated once between S1 and S2.
- REQ-034: The arbiter and pipeline control SHALL stay in fix2sfp_sched.

Verification
- REQ-035: Single value: req 0 sends fix 21'h000010 -> out_sfp 9'h020, out_id 0, two cycles after accept.
- REQ-036: Negative and zero: fix 21'h1FFFEF -> 9'h120; fix 21'h000000 -> 9'h000.
- REQ-037: Round overflow: fix 21'h00003F (pos 5, mantissa 1111 rounds up) -> exponent 3, mantissa 0 -> 9'h030.
- REQ-038: Fairness: all 4 requesters held valid, out_ready high -> ids 0,1,2,3,0,... one result per cycle.
- REQ-039: Backpressure: out_ready low for 5 cycles with requests pending -> outputs stable, at most 2 accepts, then in-order drain with no loss.
- REQ-040: Reset mid-stream: rst_n pulsed low with both stages full -> out_valid 0 immediately; after release, requester 0 is granted first.
